segment_recorder: RTL and testbench

Per-channel segment bookkeeping stage directly downstream of the sample discriminator. It consumes the discriminator's kept-batch stream and segment-start timestamps, and counts the batches in each contiguous segment. Each closed segment becomes a record of {channel, start timestamp, length}, and records from all channels are merged onto one AXI-stream for the buffer/DMA readout path.

---
 rtl/segment_recorder_pkg.sv | 22 ++
 rtl/segment_recorder_if.sv | 24 ++
 rtl/segment_recorder_tracker.sv | 94 +++++++++
 rtl/segment_recorder.sv | 73 +++++++
 tb/tb_segment_recorder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/segment_recorder_pkg.sv
// Shared widths and record layout for the segment recorder.
// Channel count and timestamp width are fixed here for the receive chain.
package segment_recorder_pkg;
    localparam int CHANNELS             = 4;
    localparam int DATA_WIDTH           = 16;
    localparam int TSTAMP_WIDTH         = 16;
    localparam int SAMPLE_INDEX_WIDTH   = 12;
    localparam int CHANNEL_WIDTH        = $clog2(CHANNELS);
    localparam int SEGMENT_RECORD_WIDTH = TSTAMP_WIDTH + SAMPLE_INDEX_WIDTH + 1 + CHANNEL_WIDTH;

    // Packed MSB first, so timestamp lands in the low bits of the record.
    typedef struct packed {
        logic [CHANNEL_WIDTH-1:0]      channel;
        logic                          saturated;
        logic [SAMPLE_INDEX_WIDTH-1:0] length;
        logic [TSTAMP_WIDTH-1:0]       timestamp;
    } segment_record_t;

    function automatic int next_channel(input int c);
        return (c + 1) % CHANNELS;
    endfunction
endpackage

// File: rtl/segment_recorder_if.sv
// Stream interfaces used at the segment recorder boundary:
// a per-channel valid-only parallel bus and a single AXI-stream.
interface Realtime_Parallel_If #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
);
    logic [CHANNELS-1:0][WIDTH-1:0] data;
    logic [CHANNELS-1:0]            valid;

    modport Master (output data, valid);
    modport Slave  (input  data, valid);
endinterface

interface Axis_If #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             last;

    modport Master (output data, valid, last, input  ready);
    modport Slave  (input  data, valid, last, output ready);
endinterface

// File: rtl/segment_recorder_tracker.sv
// One channel of segment bookkeeping: open/count/sat state, a record FIFO
// and sticky overflow/orphan flags. Record out is {sat, length, timestamp}.
module segment_tracker
    import segment_recorder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = SAMPLE_INDEX_WIDTH,
    localparam int REC_W     = TSTAMP_WIDTH + LEN_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ts_valid,
    input  logic [TSTAMP_WIDTH-1:0] ts,
    input  logic                    data_valid,
    input  logic                    flush,
    output logic [REC_W-1:0]        rec_data,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic                    overflow,
    output logic                    orphan
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    logic                    open;
    logic [TSTAMP_WIDTH-1:0] start_ts;
    logic [LEN_WIDTH-1:0]    count, cnt_inc;
    logic                    sat, sat_inc;
    logic                    push, pop, wr_en, full, empty;
    logic [REC_W-1:0]        push_rec;
    logic [REC_W-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr, rd_ptr;

    // A same-cycle batch is counted before a flush closes the segment.
    always_comb begin
        cnt_inc  = count;
        sat_inc  = sat;
        if (data_valid && open && count != LEN_MAX) begin
            cnt_inc = count + 1'b1;
            sat_inc = sat | (cnt_inc == LEN_MAX);
        end
        push     = 1'b0;
        push_rec = {sat, count, start_ts};
        if (ts_valid) begin
            push = open && (count != '0);
        end else if (flush) begin
            push     = open && (cnt_inc != '0);
            push_rec = {sat_inc, cnt_inc, start_ts};
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rec_valid = !empty;
    assign rec_data  = mem[rd_ptr[AW-1:0]];
    assign pop       = rec_valid && rec_ready;
    // A full FIFO being read this cycle still has room for the write.
    assign wr_en     = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            open     <= 1'b0;
            start_ts <= '0;
            count    <= '0;
            sat      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            orphan   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr_en) overflow <= 1'b1;
            if (data_valid && !open && !ts_valid) orphan <= 1'b1;
            if (ts_valid) begin
                open     <= 1'b1;
                start_ts <= ts;
                count    <= LEN_WIDTH'(data_valid);
                sat      <= 1'b0;
            end else if (flush) begin
                open  <= 1'b0;
                count <= '0;
                sat   <= 1'b0;
            end else begin
                count <= cnt_inc;
                sat   <= sat_inc;
            end
        end
    end
endmodule

// File: rtl/segment_recorder.sv
// Per-channel segment trackers merged onto one record stream by a
// round-robin arbiter feeding a single output register.
module segment_recorder
    import segment_recorder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = SAMPLE_INDEX_WIDTH
) (
    input  logic                      adc_clk,
    input  logic                      adc_reset,
    Realtime_Parallel_If.Slave        adc_data_in,
    Realtime_Parallel_If.Slave        adc_timestamps_in,
    input  logic [CHANNELS-1:0]       adc_flush,
    Axis_If.Master                    adc_records_out,
    output logic [CHANNELS-1:0]       adc_overflow,
    output logic [CHANNELS-1:0]       adc_orphan
);
    localparam int TRK_W = TSTAMP_WIDTH + LEN_WIDTH + 1;

    logic [CHANNELS-1:0][TRK_W-1:0] trk_data;
    logic [CHANNELS-1:0]            trk_valid, trk_ready;
    logic [CHANNEL_WIDTH-1:0]       ptr, gnt_ch;
    logic                           gnt_any, load;
    int                             idx;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_trk
        segment_tracker #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_WIDTH(LEN_WIDTH)) u_trk (
            .clk        (adc_clk),
            .reset      (adc_reset),
            .ts_valid   (adc_timestamps_in.valid[c]),
            .ts         (adc_timestamps_in.data[c]),
            .data_valid (adc_data_in.valid[c]),
            .flush      (adc_flush[c]),
            .rec_data   (trk_data[c]),
            .rec_valid  (trk_valid[c]),
            .rec_ready  (trk_ready[c]),
            .overflow   (adc_overflow[c]),
            .orphan     (adc_orphan[c])
        );
    end

    // First non-empty FIFO at or after ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        idx     = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (int'(ptr) + i) % CHANNELS;
            if (!gnt_any && trk_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = CHANNEL_WIDTH'(idx);
            end
        end
    end

    assign load      = !adc_records_out.valid || adc_records_out.ready;
    assign trk_ready = (gnt_any && load) ? (CHANNELS'(1) << gnt_ch) : '0;
    assign adc_records_out.last = 1'b1;

    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            adc_records_out.valid <= 1'b0;
            adc_records_out.data  <= '0;
            ptr                   <= '0;
        end else if (load) begin
            adc_records_out.valid <= gnt_any;
            if (gnt_any) begin
                adc_records_out.data <= {gnt_ch, trk_data[gnt_ch]};
                ptr                  <= CHANNEL_WIDTH'(next_channel(int'(gnt_ch)));
            end
        end
    end
endmodule

// File: tb/tb_segment_recorder.sv
// Scoreboard bench for segment_recorder with LEN_WIDTH=4, FIFO_DEPTH=8.
module tb_segment_recorder;
    import segment_recorder_pkg::*;

    localparam int LW = 4;
    localparam int RW = TSTAMP_WIDTH + LW + 1 + CHANNEL_WIDTH;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [CHANNELS-1:0] flush = '0;
    logic [CHANNELS-1:0] overflow, orphan;

    Realtime_Parallel_If #(.CHANNELS(CHANNELS), .WIDTH(DATA_WIDTH))   d_if ();
    Realtime_Parallel_If #(.CHANNELS(CHANNELS), .WIDTH(TSTAMP_WIDTH)) t_if ();
    Axis_If #(.WIDTH(RW)) r_if ();

    segment_recorder #(.FIFO_DEPTH(8), .LEN_WIDTH(LW)) dut (
        .adc_clk           (clk),
        .adc_reset         (rst),
        .adc_data_in       (d_if),
        .adc_timestamps_in (t_if),
        .adc_flush         (flush),
        .adc_records_out   (r_if),
        .adc_overflow      (overflow),
        .adc_orphan        (orphan)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] sb[$];
    int n_cmp = 0, n_bad = 0, exp_ptr = 0;
    bit spread = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] rec(input int ch, input bit s, input int len, input int ts);
        return {ch[CHANNEL_WIDTH-1:0], s, len[LW-1:0], ts[TSTAMP_WIDTH-1:0]};
    endfunction

    task automatic expect_rec(input int ch, input bit s, input int len, input int ts);
        sb.push_back(rec(ch, s, len, ts));
        exp_ptr = (ch + 1) % CHANNELS;
    endtask

    // One cycle of stimulus; inputs return to idle afterwards.
    task automatic step(input logic [CHANNELS-1:0] dv, input logic [CHANNELS-1:0] tsv,
                        input logic [CHANNELS-1:0] fl, input logic [15:0] ts);
        d_if.valid = dv;
        t_if.valid = tsv;
        flush      = fl;
        for (int c = 0; c < CHANNELS; c++)
            t_if.data[c] = spread ? ts + 16'(c * 'h1000) : ts;
        @(posedge clk); #1;
        d_if.valid = '0;
        t_if.valid = '0;
        flush      = '0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({"drain_", tag}, sb.size(), 0);
    endtask

    task automatic burst(input logic [15:0] ts);
        int b = exp_ptr;
        spread = 1'b1;
        step('1, '1, '0, ts);
        for (int k = 0; k < CHANNELS; k++) begin
            int c = (b + k) % CHANNELS;
            expect_rec(c, 1'b0, 1, int'(ts) + c * 'h1000);
        end
        exp_ptr = b;
        step('0, '0, '1, 16'h0);
        chk("burst_n1_valid", r_if.valid, 0);
        for (int k = 0; k < CHANNELS; k++) begin
            @(posedge clk); #1;
            chk("burst_valid", r_if.valid, 1);
        end
        @(posedge clk); #1;
        chk("burst_end_valid", r_if.valid, 0);
        spread = 1'b0;
        drain("burst");
    endtask

    always @(negedge clk) begin
        if (!rst && r_if.valid && r_if.ready) begin
            chk("last", r_if.last, 1);
            if (sb.size() == 0) chk("unexpected_rec", 0, 1);
            else chk("rec", r_if.data, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        d_if.data  = '0;
        d_if.valid = '0;
        t_if.data  = '0;
        t_if.valid = '0;
        r_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", r_if.valid, 0);
        chk("rst_data", r_if.data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_orphan", orphan, 0);

        // ch0: 5 batches in one segment
        step(4'b0001, 4'b0001, '0, 16'h100);
        repeat (4) step(4'b0001, '0, '0, 16'h0);
        expect_rec(0, 1'b0, 5, 'h100);
        step('0, '0, 4'b0001, 16'h0);
        drain("t1");

        // ch1: timestamp with same-cycle batch starts a new segment
        step('0, 4'b0010, '0, 16'h10);
        repeat (3) step(4'b0010, '0, '0, 16'h0);
        expect_rec(1, 1'b0, 3, 'h10);
        step(4'b0010, 4'b0010, '0, 16'h40);
        step(4'b0010, '0, '0, 16'h0);
        expect_rec(1, 1'b0, 2, 'h40);
        step('0, '0, 4'b0010, 16'h0);
        drain("t2");

        // ch0 orphan batch
        step(4'b0001, '0, '0, 16'h0);
        drain("t3");
        chk("orphan_set", orphan, 4'b0001);
        chk("overflow_clear", overflow, 0);

        // ch0: 10 closes while stalled; output reg + 8 FIFO slots hold 9
        r_if.ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, 4'b0001, '0, 16'(16'h200 + k));
            if (k > 0) expect_rec(0, 1'b0, 1, 'h200 + k - 1);
        end
        step('0, '0, 4'b0001, 16'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid", r_if.valid, 1);
        chk("stall_data", r_if.data, rec(0, 1'b0, 1, 'h200));
        repeat (3) @(posedge clk);
        #1;
        chk("stall_hold", r_if.data, rec(0, 1'b0, 1, 'h200));
        chk("overflow_set", overflow, 4'b0001);
        chk("orphan_sticky", orphan, 4'b0001);
        r_if.ready = 1'b1;
        drain("t4");

        // simultaneous closes, then a second burst after moving ptr
        burst(16'h300);
        step(4'b0100, 4'b0100, '0, 16'h400);
        expect_rec(2, 1'b0, 1, 'h400);
        step('0, '0, 4'b0100, 16'h0);
        drain("t5b");
        burst(16'h500);

        // ch3 saturation
        step(4'b1000, 4'b1000, '0, 16'h600);
        repeat (19) step(4'b1000, '0, '0, 16'h0);
        expect_rec(3, 1'b1, 15, 'h600);
        step('0, '0, 4'b1000, 16'h0);
        drain("t6");

        // reset with an output beat pending and ch0 open
        r_if.ready = 1'b0;
        step(4'b0010, 4'b0010, '0, 16'h700);
        step('0, '0, 4'b0010, 16'h0);
        step(4'b0001, 4'b0001, '0, 16'h710);
        repeat (3) step(4'b0001, '0, '0, 16'h0);
        @(posedge clk); #1;
        chk("pre_reset_valid", r_if.valid, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_valid", r_if.valid, 0);
        chk("post_rst_data", r_if.data, 0);
        chk("post_rst_overflow", overflow, 0);
        chk("post_rst_orphan", orphan, 0);
        r_if.ready = 1'b1;
        step('0, '0, 4'b0001, 16'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle", r_if.valid, 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
